// File: rtl/word_deser_rx_if.sv
// Serial-in / word-out bundle for word_deser_rx: bit stream from the source,
// rebuilt word with valid/ready handshake, and status back to the consumer.
interface word_deser_rx_if #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic              sdi;
  logic              sdi_valid;
  logic              frame_start;
  logic [WORD_W-1:0] word_o;
  logic              word_valid_o;
  logic              word_ready_i;
  logic              match_o;
  logic [CNT_W-1:0]  match_cnt_o;
  logic [CNT_W-1:0]  err_cnt_o;
  logic              busy_o;
  logic              overrun_o;

  // Source/consumer side (drives the bit stream and accepts words).
  modport master (
    output sdi, sdi_valid, frame_start, word_ready_i,
    input  word_o, word_valid_o, match_o, match_cnt_o, err_cnt_o, busy_o, overrun_o
  );

  // Receiver side.
  modport slave (
    input  sdi, sdi_valid, frame_start, word_ready_i,
    output word_o, word_valid_o, match_o, match_cnt_o, err_cnt_o, busy_o, overrun_o
  );
endinterface

// File: rtl/word_deser_rx.sv
// Deserializer/checker for the constant-word link: rebuilds MSB-first frames,
// compares against EXPECT and keeps saturating counters. Optional even parity
// bit per frame enabled with `define WORD_DESER_RX_PARITY_EN.
module word_deser_rx #(
  parameter int unsigned WORD_W = 32,
  parameter logic [31:0] EXPECT = 32'h0000ABCD,
  parameter int unsigned CNT_W  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  word_deser_rx_if.slave bus
);

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam word_t EXP_WORD = WORD_W'(EXPECT);

`ifdef WORD_DESER_RX_PARITY_EN
  localparam int unsigned FRAME_LEN = WORD_W + 1;
`else
  localparam int unsigned FRAME_LEN = WORD_W;
`endif
  localparam int unsigned BC_W = $clog2(FRAME_LEN + 1);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t          state;
  logic [BC_W-1:0] bit_cnt;
  word_t           shreg;
  word_t           word_q;
  logic            word_valid_q;
  logic            match_q;
  cnt_t            match_cnt_q;
  cnt_t            err_cnt_q;
  logic            overrun_q;

  logic  start_bit;
  logic  handshake;
  word_t shifted;
  word_t final_word;
  logic  final_match;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign start_bit = bus.sdi_valid & bus.frame_start;
  assign handshake = word_valid_q & bus.word_ready_i;
  assign shifted   = WORD_W'({shreg, bus.sdi});

`ifdef WORD_DESER_RX_PARITY_EN
  logic par_q;

  // Running XOR since the last frame_start; only consumed while in SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (bus.sdi_valid) begin
      par_q <= start_bit ? bus.sdi : (par_q ^ bus.sdi);
    end
  end

  // Last bit is parity: data already complete in shreg, bad parity forces a mismatch.
  assign final_word  = shreg;
  assign final_match = (shreg == EXP_WORD) && !(par_q ^ bus.sdi);
`else
  assign final_word  = shifted;
  assign final_match = (shifted == EXP_WORD);
`endif

  // Frame FSM with registered word, flags and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      match_q      <= 1'b0;
      match_cnt_q  <= '0;
      err_cnt_q    <= '0;
      overrun_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_bit) begin
            shreg   <= WORD_W'(bus.sdi);
            bit_cnt <= BC_W'(1);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.sdi_valid) begin
            if (bus.frame_start) begin
              // Truncated frame: count it and restart on this bit.
              err_cnt_q <= sat_inc(err_cnt_q);
              shreg     <= WORD_W'(bus.sdi);
              bit_cnt   <= BC_W'(1);
            end else if (bit_cnt == LAST_BIT) begin
              word_q       <= final_word;
              match_q      <= final_match;
              word_valid_q <= 1'b1;
              bit_cnt      <= '0;
              state        <= HOLD;
            end else begin
              shreg   <= shifted;
              bit_cnt <= bit_cnt + BC_W'(1);
            end
          end
        end
        HOLD: begin
          if (handshake) begin
            if (match_q) match_cnt_q <= sat_inc(match_cnt_q);
            else         err_cnt_q   <= sat_inc(err_cnt_q);
            word_valid_q <= 1'b0;
            if (start_bit) begin
              shreg   <= WORD_W'(bus.sdi);
              bit_cnt <= BC_W'(1);
              state   <= SHIFT;
            end else begin
              state <= IDLE;
            end
          end else if (start_bit) begin
            overrun_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.word_o       = word_q;
  assign bus.word_valid_o = word_valid_q;
  assign bus.match_o      = match_q;
  assign bus.match_cnt_o  = match_cnt_q;
  assign bus.err_cnt_o    = err_cnt_q;
  assign bus.overrun_o    = overrun_q;
  assign bus.busy_o       = (state != IDLE);

endmodule

// File: tb/tb_word_deser_rx.sv
// Self-checking bench for word_deser_rx: vector table of frames plus directed
// sequences for truncation, overrun, saturation, async reset and parity.
module tb_word_deser_rx;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned CNT_W   = 4;
  localparam logic [31:0] EXPECT  = 32'h0000ABCD;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  word_deser_rx_if #(.WORD_W(WORD_W), .CNT_W(CNT_W)) bus ();

  word_deser_rx #(.WORD_W(WORD_W), .EXPECT(EXPECT), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [31:0] w;
    logic        m;
  } exp_t;

  typedef struct {
    logic [31:0] w;
    bit          gaps;
    int          wait_cyc;
  } vec_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   m_match = 0;
  int   m_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted word is compared with the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.word_valid_o && bus.word_ready_i) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 64'(1), 64'(0));
      end else begin
        e = sb.pop_front();
        check("sb_word", 64'(bus.word_o), 64'(e.w));
        check("sb_match", 64'(bus.match_o), 64'(e.m));
      end
    end
  end

  task automatic reset_dut();
    rst_n = 1'b0;
    bus.sdi = 1'b0;
    bus.sdi_valid = 1'b0;
    bus.frame_start = 1'b0;
    bus.word_ready_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    m_match = 0;
    m_err = 0;
    sb.delete();
  endtask

  task automatic send_bits(input logic [31:0] w, input int nbits, input bit gaps);
    for (int i = 0; i < nbits; i++) begin
      if (gaps && i != 0) begin
        bus.sdi_valid = 1'b0;
        bus.sdi = ~bus.sdi;
        tick();
      end
      bus.sdi = w[31-i];
      bus.sdi_valid = 1'b1;
      bus.frame_start = (i == 0);
      tick();
    end
    bus.sdi_valid = 1'b0;
    bus.frame_start = 1'b0;
  endtask

`ifdef WORD_DESER_RX_PARITY_EN
  task automatic send_par(input logic p);
    bus.sdi = p;
    bus.sdi_valid = 1'b1;
    bus.frame_start = 1'b0;
    tick();
    bus.sdi_valid = 1'b0;
  endtask
`endif

  task automatic send_frame(input logic [31:0] w, input bit gaps);
    send_bits(w, int'(WORD_W), gaps);
`ifdef WORD_DESER_RX_PARITY_EN
    send_par(^w);
`endif
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_word"}, 64'(bus.word_o), 64'(0));
    check({tag, "_valid"}, 64'(bus.word_valid_o), 64'(0));
    check({tag, "_match"}, 64'(bus.match_o), 64'(0));
    check({tag, "_mcnt"}, 64'(bus.match_cnt_o), 64'(0));
    check({tag, "_ecnt"}, 64'(bus.err_cnt_o), 64'(0));
    check({tag, "_busy"}, 64'(bus.busy_o), 64'(0));
    check({tag, "_ovr"}, 64'(bus.overrun_o), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    logic exp_m;

    vecs = '{
      '{32'h0000ABCD, 1'b0, 0},
      '{32'h0000ABCE, 1'b1, 5},
      '{32'hFFFFFFFF, 1'b0, 2},
      '{32'h00000000, 1'b1, 0},
      '{32'h8000ABCD, 1'b0, 3},
      '{32'h0000ABCD, 1'b1, 1}
    };

    reset_dut();
    check_zero("reset");

    // Bits without frame_start in IDLE are ignored.
    for (int i = 0; i < 4; i++) begin
      bus.sdi = 1'b1;
      bus.sdi_valid = 1'b1;
      tick();
    end
    bus.sdi_valid = 1'b0;
    check("idle_ignore_busy", 64'(bus.busy_o), 64'(0));

    // Vector table: frame, optional sdi_valid gaps, consumer back-pressure.
    foreach (vecs[k]) begin
      exp_m = (vecs[k].w == EXPECT);
      sb.push_back('{w: vecs[k].w, m: exp_m});
      bus.word_ready_i = (vecs[k].wait_cyc == 0);
      send_frame(vecs[k].w, vecs[k].gaps);
      check("vec_latency_valid", 64'(bus.word_valid_o), 64'(1));
      check("vec_word", 64'(bus.word_o), 64'(vecs[k].w));
      check("vec_match", 64'(bus.match_o), 64'(exp_m));
      for (int c = 0; c < vecs[k].wait_cyc; c++) begin
        tick();
        check("hold_word", 64'(bus.word_o), 64'(vecs[k].w));
        check("hold_valid", 64'(bus.word_valid_o), 64'(1));
        check("hold_ecnt", 64'(bus.err_cnt_o), 64'(m_err));
        check("hold_busy", 64'(bus.busy_o), 64'(1));
      end
      bus.word_ready_i = 1'b1;
      tick();
      if (exp_m) m_match = sat(m_match + 1);
      else       m_err = sat(m_err + 1);
      check("vec_mcnt", 64'(bus.match_cnt_o), 64'(m_match));
      check("vec_ecnt", 64'(bus.err_cnt_o), 64'(m_err));
      check("vec_valid_clr", 64'(bus.word_valid_o), 64'(0));
      check("vec_idle", 64'(bus.busy_o), 64'(0));
      bus.word_ready_i = 1'b0;
    end

    // Truncated frame: restart after 10 bits.
    reset_dut();
    bus.word_ready_i = 1'b1;
    send_bits(32'h0000ABCD, 10, 1'b0);
    sb.push_back('{w: 32'h0000ABCD, m: 1'b1});
    send_frame(32'h0000ABCD, 1'b0);
    check("trunc_ecnt", 64'(bus.err_cnt_o), 64'(1));
    check("trunc_valid", 64'(bus.word_valid_o), 64'(1));
    tick();
    check("trunc_mcnt", 64'(bus.match_cnt_o), 64'(1));
    check("trunc_ecnt_after", 64'(bus.err_cnt_o), 64'(1));

    // Overrun while holding, then handshake coinciding with the next frame_start.
    reset_dut();
    sb.push_back('{w: 32'h0000ABCD, m: 1'b1});
    send_frame(32'h0000ABCD, 1'b0);
    bus.sdi = 1'b1;
    bus.sdi_valid = 1'b1;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    check("ovr_flag", 64'(bus.overrun_o), 64'(1));
    check("ovr_busy", 64'(bus.busy_o), 64'(1));
    for (int i = 0; i < 5; i++) tick();
    bus.sdi_valid = 1'b0;
    check("ovr_word_kept", 64'(bus.word_o), 64'(32'h0000ABCD));
    check("ovr_valid_kept", 64'(bus.word_valid_o), 64'(1));
    sb.push_back('{w: 32'h12345678, m: 1'b0});
    bus.word_ready_i = 1'b1;
    send_frame(32'h12345678, 1'b0);
    check("ovr_new_word", 64'(bus.word_o), 64'(32'h12345678));
    check("ovr_new_valid", 64'(bus.word_valid_o), 64'(1));
    check("ovr_sticky", 64'(bus.overrun_o), 64'(1));
    check("ovr_mcnt", 64'(bus.match_cnt_o), 64'(1));
    tick();
    check("ovr_ecnt", 64'(bus.err_cnt_o), 64'(1));
    bus.word_ready_i = 1'b0;

    // Reset while holding a word clears everything, including the sticky overrun.
    send_frame(32'h0000ABCD, 1'b0);
    check("hold_pre_rst_valid", 64'(bus.word_valid_o), 64'(1));
    #2 rst_n = 1'b0;
    #1 check_zero("rst_hold");
    rst_n = 1'b1;
    tick();

    // Counter saturation.
    reset_dut();
    bus.word_ready_i = 1'b1;
    for (int f = 0; f < 20; f++) begin
      sb.push_back('{w: 32'h0000ABCD, m: 1'b1});
      send_frame(32'h0000ABCD, 1'b0);
      tick();
      m_match = sat(m_match + 1);
      check("sat_mcnt", 64'(bus.match_cnt_o), 64'(m_match));
    end
    check("sat_final", 64'(bus.match_cnt_o), 64'(15));

    // Async reset mid-frame.
    bus.word_ready_i = 1'b0;
    send_bits(32'h0000ABCD, 10, 1'b0);
    check("midframe_busy", 64'(bus.busy_o), 64'(1));
    #3 rst_n = 1'b0;
    #1 check_zero("rst_mid");
    rst_n = 1'b1;
    tick();

`ifdef WORD_DESER_RX_PARITY_EN
    // Wrong parity then correct parity.
    reset_dut();
    bus.word_ready_i = 1'b1;
    sb.push_back('{w: 32'h0000ABCD, m: 1'b0});
    send_bits(32'h0000ABCD, int'(WORD_W), 1'b0);
    send_par(~^32'h0000ABCD);
    check("par_bad_match", 64'(bus.match_o), 64'(0));
    tick();
    check("par_bad_ecnt", 64'(bus.err_cnt_o), 64'(1));
    check("par_bad_mcnt", 64'(bus.match_cnt_o), 64'(0));
    sb.push_back('{w: 32'h0000ABCD, m: 1'b1});
    send_bits(32'h0000ABCD, int'(WORD_W), 1'b0);
    send_par(^32'h0000ABCD);
    check("par_ok_match", 64'(bus.match_o), 64'(1));
    tick();
    check("par_ok_mcnt", 64'(bus.match_cnt_o), 64'(1));
    check("par_ok_ecnt", 64'(bus.err_cnt_o), 64'(1));
`endif

    tick();
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/word_deser_rx.md
Name: word_deser_rx

Overview:
- Receive end of the 32-bit constant-word link: the deserializer and checker for words shifted out serially, MSB first, by a word source.
- Rebuilds each word, presents it on a valid/ready output, and compares it against the expected typedef'd word value (default 32'h0000ABCD).
- Keeps saturating match and error counters for simulation and synthesis regression checks.

Parameters:
- WORD_W, 32, width of the reconstructed word (bits per frame).
- EXPECT, 32'h0000ABCD, expected word value; only the low WORD_W bits are used.
- CNT_W, 16, width of the match and error counters.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sdi  input  1  serial data bit, MSB first.
- sdi_valid  input  1  sdi is sampled only in cycles where this is 1.
- frame_start  input  1  qualified by sdi_valid; marks that bit as the MSB of a new frame.
- word_o  output  WORD_W  reconstructed word.
- word_valid_o  output  1  word_o is valid.
- word_ready_i  input  1  consumer accepts word_o.
- match_o  output  1  word_o == EXPECT; meaningful only while word_valid_o=1.
- match_cnt_o  output  CNT_W  count of accepted words that matched.
- err_cnt_o  output  CNT_W  count of mismatches, truncated frames and (with the option) parity errors.
- busy_o  output  1  FSM is not IDLE.
- overrun_o  output  1  sticky flag: a frame started while a word was still held.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, bit count=0, shift register=0, word_o=0, word_valid_o=0, match_o=0, both counters=0, busy_o=0, overrun_o=0.
- FSM states: IDLE, SHIFT, HOLD.
- IDLE:
  - sdi_valid & frame_start: load sdi into the LSB of the shift register, bit count=1, go to SHIFT.
  - sdi_valid without frame_start: bit is ignored.
- SHIFT, on each sdi_valid bit:
  - Shift the register left by one and insert sdi; increment bit count.
  - Gaps in sdi_valid are allowed and stall the frame.
- SHIFT, on the WORD_W-th bit:
  - Next cycle: word_o = register, word_valid_o=1, match_o = (register == EXPECT), state=HOLD.
  - Latency: word_valid_o rises exactly 1 cycle after the last bit is sampled.
- SHIFT, frame_start & sdi_valid before the WORD_W-th bit (truncated frame):
  - err_cnt increments.
  - Frame restarts with this bit as the MSB, bit count=1.
- HOLD:
  - word_o, match_o and word_valid_o are held stable until word_valid_o & word_ready_i.
  - On that handshake: match_o=1 increments match_cnt, otherwise err_cnt; clear word_valid_o; go to IDLE.
- Handshake in the same cycle as frame_start & sdi_valid: the handshake completes and the new frame is accepted (go to SHIFT, bit count=1). No overrun.
- frame_start & sdi_valid in HOLD without a handshake: overrun_o set (sticky until reset), the bit is dropped, stay in HOLD.
- Plain sdi_valid in HOLD without frame_start: ignored.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Reset mid-frame or mid-HOLD: everything returns to reset values immediately. The partial or held word is lost and not counted.
- busy_o = (state != IDLE), combinational from the state register.

Optional Feature:
- Macro: WORD_DESER_RX_PARITY_EN.
- When defined:
  - Each frame carries one extra even-parity bit after the WORD_W data bits, so the frame is WORD_W+1 valid bits.
  - word_valid_o rises 1 cycle after the parity bit is sampled.
  - On parity error: word is still presented, match_o forced to 0, err_cnt increments once at the handshake (not twice).
  - A truncated frame includes a frame_start arriving in the parity-bit slot.
- When undefined: no parity bit and frame length is exactly WORD_W; behaviour as above.

Test Plan:
- Reset then send 32'h0000ABCD MSB first, sdi_valid continuous, word_ready_i=1 → word_valid_o 1 cycle after bit 32, word_o=32'h0000ABCD, match_o=1, match_cnt_o=1, err_cnt_o=0.
- Send 32'h0000ABCE with sdi_valid toggling 1/0 and word_ready_i held low for 5 cycles → word stable for the full wait, match_o=0, err_cnt_o=1 only after the handshake.
- After 10 bits of a frame, assert frame_start and send full 32'h0000ABCD → err_cnt_o=1 (truncated), then match_cnt_o=1.
- Hold a word with word_ready_i=0 and start a new frame → overrun_o=1, that frame is dropped. Then raise word_ready_i in the same cycle as the next frame_start → new frame is accepted and overrun_o stays 1.
- Drive CNT_W=4 and 20 matching frames → match_cnt_o saturates at 15. Assert rst_n=0 mid-frame → all outputs 0 asynchronously.
- With WORD_DESER_RX_PARITY_EN defined: send 32'h0000ABCD plus a wrong parity bit → match_o=0, err_cnt_o=1 (exactly one increment). Then send the correct parity bit → match_cnt_o=1.
